// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The pipeline side drives operations in; the unit answers with HI/LO state,
// MF read data and the busy/done/hazard status.
interface mult_div_unit_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int ALU_OP_WIDTH = 5
) ();

   logic                    stall;
   logic                    cancel;
   logic                    start;
   logic [ALU_OP_WIDTH-1:0] op;
   logic [DATA_WIDTH-1:0]   rs;
   logic [DATA_WIDTH-1:0]   rt;
   logic [DATA_WIDTH-1:0]   rd;
   logic                    busy;
   logic                    done;
   logic                    hilo_hazard;
   logic [DATA_WIDTH-1:0]   hi;
   logic [DATA_WIDTH-1:0]   lo;

   modport master (
      output stall, cancel, start, op, rs, rt,
      input  rd, busy, done, hilo_hazard, hi, lo
   );

   modport slave (
      input  stall, cancel, start, op, rs, rt,
      output rd, busy, done, hilo_hazard, hi, lo
   );

endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Multiplies use radix-2 shift-add and divides use radix-2 restoring division,
// both on operand magnitudes, with the signs fixed up in a final FIX cycle.
// MTHI/MTLO write HI/LO directly; MFHI/MFLO read them combinationally.
module mult_div_unit #(
   parameter int DATA_WIDTH   = 32,
   parameter int ALU_OP_WIDTH = 5,
   parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL  = ALU_OP_WIDTH'(24),
   parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MULU = ALU_OP_WIDTH'(25),
   parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_DIV  = ALU_OP_WIDTH'(26),
   parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_DIVU = ALU_OP_WIDTH'(27),
   parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MFHI = ALU_OP_WIDTH'(16),
   parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MTHI = ALU_OP_WIDTH'(17),
   parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MFLO = ALU_OP_WIDTH'(18),
   parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MTLO = ALU_OP_WIDTH'(19)
) (
   input logic            clk,
   input logic            rst_n,
   mult_div_unit_if.slave bus
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [W-1:0]    operand_q, operand_d;
   logic [W-1:0]    workHi_q, workHi_d;
   logic [W-1:0]    workLo_q, workLo_d;
   logic            isDiv_q, isDiv_d;
   logic            negRes_q, negRes_d;
   logic            negRem_q, negRem_d;
   logic            divZero_q, divZero_d;
   logic [W-1:0]    hi_q, hi_d;
   logic [W-1:0]    lo_q, lo_d;
   logic            done_q, done_d;

   logic            opMul, opMulu, opDiv, opDivu;
   logic            opMulDiv, opSigned, opIsDiv, opAny;
   logic            opMtHi, opMtLo, opMfHi, opMfLo;
   logic            idleAccept, issue, calcStep, fixWrite;
   logic            rsNeg, rtNeg;
   logic [W-1:0]    rsMag, rtMag;
   logic [W:0]      mulSum, divShift, divTrial;
   logic [2*W-1:0]  prodMag, prodFix;
   logic [W-1:0]    quoFix, remFix, fixHi, fixLo;

   // Decode the operation and the qualified issue/step/write conditions
   always_comb begin
      opMul      = (bus.op == ALU_OP_MUL);
      opMulu     = (bus.op == ALU_OP_MULU);
      opDiv      = (bus.op == ALU_OP_DIV);
      opDivu     = (bus.op == ALU_OP_DIVU);
      opMtHi     = (bus.op == ALU_OP_MTHI);
      opMtLo     = (bus.op == ALU_OP_MTLO);
      opMfHi     = (bus.op == ALU_OP_MFHI);
      opMfLo     = (bus.op == ALU_OP_MFLO);
      opMulDiv   = opMul | opMulu | opDiv | opDivu;
      opSigned   = opMul | opDiv;
      opIsDiv    = opDiv | opDivu;
      opAny      = opMulDiv | opMtHi | opMtLo | opMfHi | opMfLo;
      idleAccept = (state_q == IDLE) & bus.start & ~bus.stall & ~bus.cancel;
      issue      = idleAccept & opMulDiv;
      calcStep   = (state_q == CALC) & ~bus.stall & ~bus.cancel;
      fixWrite   = (state_q == FIX) & ~bus.stall & ~bus.cancel;
   end

   // Operand magnitudes for signed ops, one radix-2 step, and the FIX-cycle sign correction
   always_comb begin
      rsNeg    = opSigned & bus.rs[W-1];
      rtNeg    = opSigned & bus.rt[W-1];
      rsMag    = rsNeg ? -bus.rs : bus.rs;
      rtMag    = rtNeg ? -bus.rt : bus.rt;
      mulSum   = {1'b0, workHi_q} + (workLo_q[0] ? {1'b0, operand_q} : {(W+1){1'b0}});
      divShift = {workHi_q, workLo_q[W-1]};
      divTrial = divShift - {1'b0, operand_q};
      prodMag  = {workHi_q, workLo_q};
      prodFix  = negRes_q ? -prodMag : prodMag;
      quoFix   = negRes_q ? -workLo_q : workLo_q;
      remFix   = negRem_q ? -workHi_q : workHi_q;
      if (isDiv_q) begin
         fixHi = remFix;
         fixLo = divZero_q ? {W{1'b1}} : quoFix;
      end else begin
         fixHi = prodFix[2*W-1:W];
         fixLo = prodFix[W-1:0];
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: cancel always wins, stall holds CALC and FIX
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (issue) state_d = CALC;
         end
         CALC: begin
            if (bus.cancel) state_d = IDLE;
            else if (!bus.stall && count_q == CW'(1)) state_d = FIX;
         end
         FIX: begin
            if (bus.cancel) state_d = IDLE;
            else if (!bus.stall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs and the combinational MF read port
   always_comb begin
      bus.busy        = (state_q != IDLE);
      bus.hilo_hazard = bus.start & bus.busy & opAny;
      bus.done        = done_q;
      bus.hi          = hi_q;
      bus.lo          = lo_q;
      bus.rd          = '0;
      if (bus.start && !bus.busy) begin
         if (opMfHi) bus.rd = hi_q;
         else if (opMfLo) bus.rd = lo_q;
      end
   end

   // Datapath next values: load on issue, iterate in CALC, commit HI/LO on FIX or MT
   always_comb begin
      count_d   = count_q;
      operand_d = operand_q;
      workHi_d  = workHi_q;
      workLo_d  = workLo_q;
      isDiv_d   = isDiv_q;
      negRes_d  = negRes_q;
      negRem_d  = negRem_q;
      divZero_d = divZero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = fixWrite;
      if (issue) begin
         count_d   = CW'(DATA_WIDTH);
         isDiv_d   = opIsDiv;
         negRes_d  = rsNeg ^ rtNeg;
         negRem_d  = rsNeg;
         divZero_d = opIsDiv & (bus.rt == '0);
         workHi_d  = '0;
         if (opIsDiv) begin
            operand_d = rtMag;
            workLo_d  = rsMag;
         end else begin
            operand_d = rsMag;
            workLo_d  = rtMag;
         end
      end else if (calcStep) begin
         count_d = count_q - CW'(1);
         if (isDiv_q) begin
            if (!divTrial[W]) begin
               workHi_d = divTrial[W-1:0];
               workLo_d = {workLo_q[W-2:0], 1'b1};
            end else begin
               workHi_d = divShift[W-1:0];
               workLo_d = {workLo_q[W-2:0], 1'b0};
            end
         end else begin
            workHi_d = mulSum[W:1];
            workLo_d = {mulSum[0], workLo_q[W-1:1]};
         end
      end
      if (fixWrite) begin
         hi_d = fixHi;
         lo_d = fixLo;
      end else if (idleAccept && opMtHi) begin
         hi_d = bus.rs;
      end else if (idleAccept && opMtLo) begin
         lo_d = bus.rs;
      end
   end

   // Datapath and architectural HI/LO registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q   <= '0;
         operand_q <= '0;
         workHi_q  <= '0;
         workLo_q  <= '0;
         isDiv_q   <= 1'b0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         divZero_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         operand_q <= operand_d;
         workHi_q  <= workHi_d;
         workLo_q  <= workLo_d;
         isDiv_q   <= isDiv_d;
         negRes_q  <= negRes_d;
         negRem_q  <= negRem_d;
         divZero_q <= divZero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized
// mul/div/MT/MF traffic compared against an arithmetic reference model.
module tb_mult_div_unit;

   localparam int DW = 32;
   localparam int OW = 5;
   localparam logic [OW-1:0] OP_MUL  = 5'd24;
   localparam logic [OW-1:0] OP_MULU = 5'd25;
   localparam logic [OW-1:0] OP_DIV  = 5'd26;
   localparam logic [OW-1:0] OP_DIVU = 5'd27;
   localparam logic [OW-1:0] OP_MFHI = 5'd16;
   localparam logic [OW-1:0] OP_MTHI = 5'd17;
   localparam logic [OW-1:0] OP_MFLO = 5'd18;
   localparam logic [OW-1:0] OP_MTLO = 5'd19;

   logic clk;
   logic rst_n;
   int   checkCount;
   int   errorCount;
   logic [DW-1:0] modelHi;
   logic [DW-1:0] modelLo;

   mult_div_unit_if #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(OW)) bus ();

   mult_div_unit #(
      .DATA_WIDTH(DW), .ALU_OP_WIDTH(OW),
      .ALU_OP_MUL(OP_MUL), .ALU_OP_MULU(OP_MULU),
      .ALU_OP_DIV(OP_DIV), .ALU_OP_DIVU(OP_DIVU),
      .ALU_OP_MFHI(OP_MFHI), .ALU_OP_MTHI(OP_MTHI),
      .ALU_OP_MFLO(OP_MFLO), .ALU_OP_MTLO(OP_MTLO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run can never hang
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference: HI/LO results from plain arithmetic on the operands
   function automatic void refCompute(input logic [OW-1:0] opIn, input logic [DW-1:0] a,
                                      input logic [DW-1:0] b, output logic [DW-1:0] h,
                                      output logic [DW-1:0] l);
      longint sa, sb, sq, sr;
      logic [63:0] ua, ub, up, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      h = '0;
      l = '0;
      if (opIn == OP_MUL) begin
         sq = sa * sb;
         h = sq[63:32];
         l = sq[31:0];
      end else if (opIn == OP_MULU) begin
         up = ua * ub;
         h = up[63:32];
         l = up[31:0];
      end else if (b == 0) begin
         h = a;
         l = '1;
      end else if (opIn == OP_DIV) begin
         sq = sa / sb;
         sr = sa % sb;
         h = sr[31:0];
         l = sq[31:0];
      end else begin
         uq = ua / ub;
         ur = ua % ub;
         h = ur[31:0];
         l = uq[31:0];
      end
   endfunction

   function automatic logic [DW-1:0] randOperand();
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Issue a mul/div, optionally stall mid-CALC, poke an MTLO while busy,
   // or read HI in the done cycle; then check latency, busy length and HI/LO
   task automatic applyStimulus(input logic [OW-1:0] opIn, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input int stallAt, input int stallLen,
                                input bit readHiInDone, input bit mtDuringBusy);
      logic [DW-1:0] expHi, expLo;
      int cycles, busyCycles;
      refCompute(opIn, a, b, expHi, expLo);
      bus.start = 1'b1;
      bus.op    = opIn;
      bus.rs    = a;
      bus.rt    = b;
      stepCycle();
      bus.start  = 1'b0;
      cycles     = 1;
      busyCycles = 0;
      while (bus.done !== 1'b1 && cycles < 200) begin
         if (bus.busy === 1'b1) busyCycles++;
         bus.stall = (cycles >= stallAt) && (cycles < stallAt + stallLen);
         if (mtDuringBusy && cycles == 5) begin
            bus.start = 1'b1;
            bus.op    = OP_MTLO;
            bus.rs    = 32'h0000_1234;
            #1;
            checkOutput("hazardWhileBusy", bus.hilo_hazard, 1);
            checkOutput("rdWhileBusy", bus.rd, 0);
         end else begin
            bus.start = 1'b0;
         end
         stepCycle();
         cycles++;
      end
      bus.stall = 1'b0;
      bus.start = 1'b0;
      checkOutput("doneLatency", cycles, DW + 2 + stallLen);
      checkOutput("busyCycles", busyCycles, DW + 1 + stallLen);
      checkOutput("hiResult", bus.hi, expHi);
      checkOutput("loResult", bus.lo, expLo);
      modelHi = expHi;
      modelLo = expLo;
      if (readHiInDone) begin
         bus.start = 1'b1;
         bus.op    = OP_MFHI;
         #1;
         checkOutput("mfhiInDone", bus.rd, expHi);
      end
      stepCycle();
      bus.start = 1'b0;
      checkOutput("donePulse", bus.done, 0);
   endtask

   task automatic mtWrite(input logic [OW-1:0] opIn, input logic [DW-1:0] value);
      bus.start = 1'b1;
      bus.op    = opIn;
      bus.rs    = value;
      stepCycle();
      bus.start = 1'b0;
      if (opIn == OP_MTHI) modelHi = value;
      else modelLo = value;
      checkOutput("mtHi", bus.hi, modelHi);
      checkOutput("mtLo", bus.lo, modelLo);
   endtask

   task automatic mfRead(input logic [OW-1:0] opIn);
      bus.start = 1'b1;
      bus.op    = opIn;
      #1;
      checkOutput("mfRead", bus.rd, (opIn == OP_MFHI) ? modelHi : modelLo);
      stepCycle();
      bus.start = 1'b0;
   endtask

   // Start a MUL 5*5 and interrupt it at cycle 10 with cancel or reset
   task automatic interruptMul(input bit useReset);
      int sawDone;
      bus.start = 1'b1;
      bus.op    = OP_MUL;
      bus.rs    = 32'd5;
      bus.rt    = 32'd5;
      stepCycle();
      bus.start = 1'b0;
      for (int c = 1; c < 10; c++) stepCycle();
      if (useReset) rst_n = 1'b0;
      else bus.cancel = 1'b1;
      stepCycle();
      if (useReset) begin
         modelHi = '0;
         modelLo = '0;
      end
      checkOutput(useReset ? "busyAfterReset" : "busyAfterCancel", bus.busy, 0);
      rst_n      = 1'b1;
      bus.cancel = 1'b0;
      sawDone    = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done === 1'b1) sawDone = 1;
         stepCycle();
      end
      checkOutput(useReset ? "noDoneReset" : "noDoneCancel", sawDone, 0);
      checkOutput(useReset ? "hiAfterReset" : "hiAfterCancel", bus.hi, modelHi);
      checkOutput(useReset ? "loAfterReset" : "loAfterCancel", bus.lo, modelLo);
   endtask

   // Main sequence: reset, directed cases, then randomized traffic
   initial begin
      checkCount = 0;
      errorCount = 0;
      modelHi    = '0;
      modelLo    = '0;
      rst_n      = 1'b0;
      bus.stall  = 1'b0;
      bus.cancel = 1'b0;
      bus.start  = 1'b0;
      bus.op     = '0;
      bus.rs     = '0;
      bus.rt     = '0;
      repeat (3) stepCycle();
      checkOutput("resetBusy", bus.busy, 0);
      checkOutput("resetDone", bus.done, 0);
      checkOutput("resetHi", bus.hi, 0);
      checkOutput("resetLo", bus.lo, 0);
      rst_n = 1'b1;
      stepCycle();

      applyStimulus(OP_MUL, 32'hFFFF_FFFD, 32'd7, 0, 0, 1'b0, 1'b0);
      checkOutput("mulNegHi", modelHi, 32'hFFFF_FFFF);
      checkOutput("mulNegLo", modelLo, 32'hFFFF_FFEB);
      applyStimulus(OP_MULU, 32'hFFFF_FFFF, 32'd2, 0, 0, 1'b1, 1'b0);
      applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, 1'b0);
      applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
      applyStimulus(OP_DIVU, 32'd7, 32'd0, 0, 0, 1'b0, 1'b1);
      mtWrite(OP_MTHI, 32'hA5A5_A5A5);
      applyStimulus(OP_DIV, 32'd100, 32'd7, 10, 5, 1'b0, 1'b0);
      mtWrite(OP_MTHI, 32'hA5A5_A5A5);
      interruptMul(1'b0);
      interruptMul(1'b1);

      bus.start = 1'b1;
      bus.op    = 5'd0;
      bus.rs    = 32'hDEAD_BEEF;
      #1;
      checkOutput("rdOtherOp", bus.rd, 0);
      stepCycle();
      bus.start = 1'b0;
      checkOutput("otherOpHi", bus.hi, modelHi);
      checkOutput("otherOpLo", bus.lo, modelLo);

      for (int i = 0; i < 30; i++) begin
         int kind;
         logic [OW-1:0] rop;
         kind = $urandom_range(0, 9);
         if (kind <= 5) begin
            case ($urandom_range(0, 3))
               0: rop = OP_MUL;
               1: rop = OP_MULU;
               2: rop = OP_DIV;
               default: rop = OP_DIVU;
            endcase
            applyStimulus(rop, randOperand(), randOperand(),
                          $urandom_range(2, 25), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0);
         end else if (kind <= 7) begin
            mtWrite(($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, 32'($urandom));
         end else begin
            mfRead(($urandom_range(0, 1) == 0) ? OP_MFHI : OP_MFLO);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Executes MUL, MULU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Sits in EX beside arithmetic_logic_unit and replaces the ALU's single-cycle combinational mul/div and HI/LO handling.
- Raises a hazard request so the pipeline stalls any HI/LO consumer while an operation is in flight.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; any even value >= 8
ALU_OP_WIDTH, 5, width of op; encodings come from defines.v (ALU_OP_MUL, ALU_OP_MULU, ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_MFHI, ALU_OP_MFLO, plus new ALU_OP_MTHI and ALU_OP_MTLO)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  pipeline stall; freezes iteration and blocks issue
cancel  input  1  flush; aborts the in-flight op
start  input  1  op/rs/rt valid this cycle
op  input  ALU_OP_WIDTH  operation
rs  input  DATA_WIDTH  dividend / multiplicand / MT data
rt  input  DATA_WIDTH  divisor / multiplier
rd  output  DATA_WIDTH  MFHI/MFLO result (combinational), else 0
busy  output  1  high in CALC and FIX
done  output  1  one-cycle pulse after HI/LO written by mul/div
hilo_hazard  output  1  start & busy & op is any of the 8 ops
hi  output  DATA_WIDTH  HI register
lo  output  DATA_WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at edge, any state): state=IDLE; hi=lo=0; busy=0; done=0; iteration counter=0. This includes reset mid-operation.
- States: IDLE, CALC, FIX.
- Issue: in IDLE, start & !stall & !cancel with a mul/div op latches operands, records signed/unsigned and the op kind, and moves to CALC with count=DATA_WIDTH.
  - Signed ops latch the magnitudes of rs/rt plus the result signs.
  - Any start while busy is ignored; hilo_hazard=1 in that case.
- CALC:
  - Each cycle with !stall performs one radix-2 step and decrements count; a stall cycle holds everything.
  - Multiply is shift-add into a 2*DATA_WIDTH accumulator.
  - Divide is restoring: shift remainder, trial subtract, quotient bit.
  - When count reaches 0, go to FIX.
- FIX (one cycle, stall holds it):
  - Apply sign correction. Product is negated if the signs differ. Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Write {hi,lo} (mul) or hi=remainder, lo=quotient (div).
  - Return to IDLE; done=1 for the following cycle only.
- Latency: start edge at cycle N -> hi/lo valid and done=1 in cycle N+DATA_WIDTH+2, with no stalls; each stall cycle adds one.
- Back-to-back: a start in the cycle done=1 is accepted.
- Divide by zero: no exception; lo=all ones, hi=rs, for both signed and unsigned.
- Signed overflow: most-negative / -1 gives lo=most-negative, hi=0.
- cancel:
  - In CALC or FIX, return to IDLE next edge; hi/lo unchanged; no done.
  - cancel beats the FIX write in the same cycle.
  - In IDLE, cancel suppresses issue.
- MTHI/MTLO:
  - In IDLE with start & !stall & !cancel: hi<=rs or lo<=rs at the next edge.
  - While busy, the op is ignored and hazard is raised.
- MFHI/MFLO:
  - rd=hi or lo combinationally when start & !busy.
  - While busy, rd=0 and hazard is raised.
  - Reading in the cycle done=1 returns the new value.
- Only mul/div/MT ops issue; all other op codes are ignored. rd is 0 except for MFHI/MFLO.

Test Plan:
- MUL rs=0xFFFFFFFD(-3), rt=7 -> after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also check busy=1 for exactly 33 cycles.
- MULU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE. Then MFHI in the done cycle -> rd=1.
- DIV rs=0xFFFFFFF9(-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7. MTLO 0x1234 while busy -> hilo_hazard=1 and lo unaffected.
- MTHI 0xA5A5A5A5, then DIV 100/7 with stall=1 for 5 cycles mid-CALC -> done after 39 cycles, lo=14, hi=2.
- MUL 5*5, assert cancel at cycle 10 -> no done, hi=0xA5A5A5A5 kept.
  - Repeat with rst_n=0 at cycle 10 -> hi=lo=0, busy=0 next cycle.
